// File: rtl/relu_maxpool.sv
// relu_maxpool: activation stage for one accumulator column.
// Applies ReLU to every conv result. It can also run 2x2 stride-2 max pooling
// over the raster-ordered ofmap stream.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   conv_valid_i    conv result beat valid (every beat accepted)
//   conv_last_i     last beat of the current ofmap
//   conv_result_i   signed conv result
//   ofmap_size_i    ofmap edge length, sampled on the first beat of a map
//   pool_en_i       1: ReLU + 2x2 maxpool, 0: ReLU only (sampled with size)
//   act_valid_o     output beat valid (1-cycle pulse)
//   act_last_o      last output beat of the current map
//   act_data_o      activation result (always non-negative)
//   err_o           sticky framing error
module relu_maxpool #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SIZE_W    = 5,
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              conv_valid_i,
    input  logic              conv_last_i,
    input  logic [DATA_W-1:0] conv_result_i,
    input  logic [SIZE_W-1:0] ofmap_size_i,
    input  logic              pool_en_i,
    output logic              act_valid_o,
    output logic              act_last_o,
    output logic [DATA_W-1:0] act_data_o,
    output logic              err_o
);

    localparam int unsigned BUF_AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              pe_q, pe_d;
    logic [SIZE_W-1:0] row_q, row_d;
    logic [SIZE_W-1:0] col_q, col_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] lbuf_q [BUF_DEPTH];
    logic [DATA_W-1:0] lbuf_d [BUF_DEPTH];
    logic              act_valid_q, act_valid_d;
    logic              act_last_q, act_last_d;
    logic [DATA_W-1:0] act_data_q, act_data_d;
    logic              err_q, err_d;

    // Effective per-beat configuration and position
    logic [SIZE_W-1:0] size_c;
    logic              pe_c;
    logic [SIZE_W-1:0] row_c;
    logic [SIZE_W-1:0] col_c;
    logic [SIZE_W-1:0] size_m1_c;
    logic [SIZE_W-1:0] span_c;
    logic [SIZE_W-1:0] span_m1_c;
    logic              final_c;
    logic              in_win_c;
    logic              last_win_c;
    logic [BUF_AW-1:0] lidx_c;
    logic [DATA_W-1:0] relu_c;
    logic [DATA_W-1:0] pair_c;
    logic [DATA_W-1:0] quad_c;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Datapath views: an IDLE beat uses the live config inputs and starts at (0,0)
    always_comb begin
        size_c     = (state_q == ST_IDLE) ? ofmap_size_i : size_q;
        pe_c       = (state_q == ST_IDLE) ? pool_en_i    : pe_q;
        row_c      = (state_q == ST_IDLE) ? '0           : row_q;
        col_c      = (state_q == ST_IDLE) ? '0           : col_q;
        size_m1_c  = size_c - SIZE_W'(1);
        // 2P: the part of the map covered by complete windows (drops odd row/col)
        span_c     = {size_c[SIZE_W-1:1], 1'b0};
        span_m1_c  = span_c - SIZE_W'(1);
        final_c    = (row_c == size_m1_c) && (col_c == size_m1_c);
        in_win_c   = (row_c < span_c) && (col_c < span_c);
        last_win_c = (row_c == span_m1_c) && (col_c == span_m1_c);
        lidx_c     = BUF_AW'(col_c >> 1);
        relu_c     = conv_result_i[DATA_W-1] ? '0 : conv_result_i;
        pair_c     = umax(hold_q, relu_c);
        quad_c     = umax(lbuf_q[lidx_c], pair_c);
    end

    // Next-state, counters, pooling storage and output beat
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        pe_d        = pe_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_d      = hold_q;
        lbuf_d      = lbuf_q;
        act_valid_d = 1'b0;
        act_last_d  = 1'b0;
        act_data_d  = '0;
        err_d       = err_q;

        if (conv_valid_i) begin
            size_d = size_c;
            pe_d   = pe_c;

            if (!pe_c) begin
                act_valid_d = 1'b1;
                act_data_d  = relu_c;
                act_last_d  = conv_last_i;
            end else if (in_win_c) begin
                case ({row_c[0], col_c[0]})
                    2'b01: lbuf_d[lidx_c] = pair_c;
                    2'b11: begin
                        act_valid_d = 1'b1;
                        act_data_d  = quad_c;
                        // A truncated or overrun map never flags its last window
                        act_last_d  = last_win_c && (final_c == conv_last_i);
                    end
                    default: hold_d = relu_c;
                endcase
            end

            if (conv_last_i != final_c) begin
                err_d = 1'b1;
            end

            if (conv_last_i || final_c) begin
                state_d = ST_IDLE;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = ST_RUN;
                if (col_c == size_m1_c) begin
                    col_d = '0;
                    row_d = row_c + SIZE_W'(1);
                end else begin
                    col_d = col_c + SIZE_W'(1);
                    row_d = row_c;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            pe_q        <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            act_valid_q <= 1'b0;
            act_last_q  <= 1'b0;
            act_data_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                lbuf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            pe_q        <= pe_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_q      <= hold_d;
            act_valid_q <= act_valid_d;
            act_last_q  <= act_last_d;
            act_data_q  <= act_data_d;
            err_q       <= err_d;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                lbuf_q[i] <= lbuf_d[i];
            end
        end
    end

    assign act_valid_o = act_valid_q;
    assign act_last_o  = act_last_q;
    assign act_data_o  = act_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: scoreboard bench for relu_maxpool.
// The driver pushes the expected output beats computed from the full input map.
// The monitor pops and checks them as the DUT emits them.
module tb_relu_maxpool;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SIZE_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              conv_valid_i;
    logic              conv_last_i;
    logic [DATA_W-1:0] conv_result_i;
    logic [SIZE_W-1:0] ofmap_size_i;
    logic              pool_en_i;
    logic              act_valid_o;
    logic              act_last_o;
    logic [DATA_W-1:0] act_data_o;
    logic              err_o;

    relu_maxpool #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .BUF_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .conv_valid_i (conv_valid_i),
        .conv_last_i  (conv_last_i),
        .conv_result_i(conv_result_i),
        .ofmap_size_i (ofmap_size_i),
        .pool_en_i    (pool_en_i),
        .act_valid_o  (act_valid_o),
        .act_last_o   (act_last_o),
        .act_data_o   (act_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
        int due;
    } exp_t;

    exp_t sb[$];
    int   vals[1024];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Drives n beats from vals[] for one map; conv_last on beat last_at (-1: never)
    task automatic drive_map(input int s, input bit pe, input int n, input int last_at);
        int row, col, p, m;
        exp_t e;
        p = s / 2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            conv_valid_i  = 1'b1;
            conv_result_i = DATA_W'(vals[i]);
            conv_last_i   = (i == last_at);
            if (i == 0) begin
                ofmap_size_i = SIZE_W'(s);
                pool_en_i    = pe;
            end else begin
                // Config must be ignored mid-map
                ofmap_size_i = SIZE_W'($urandom);
                pool_en_i    = 1'($urandom);
            end
            row = i / s;
            col = i % s;
            if (!pe) begin
                e.data = relu(vals[i]);
                e.last = (i == last_at);
                e.due  = cyc + 1;
                sb.push_back(e);
            end else if (row < 2 * p && col < 2 * p && row % 2 == 1 && col % 2 == 1) begin
                m = max2(max2(relu(vals[(row - 1) * s + col - 1]), relu(vals[(row - 1) * s + col])),
                         max2(relu(vals[row * s + col - 1]), relu(vals[i])));
                e.data = m;
                e.last = (row == 2 * p - 1) && (col == 2 * p - 1) &&
                         ((i == s * s - 1) == (i == last_at));
                e.due  = cyc + 1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        conv_valid_i = 1'b0;
        conv_last_i  = 1'b0;
    endtask

    // Monitor: every output beat must match the scoreboard head, on time
    always @(negedge clk) begin
        if (rst_n) begin
            if (act_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", int'(act_data_o), e.data);
                    chk("last", int'(act_last_o), int'(e.last));
                    chk("latency", cyc, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("missing_valid", 0, 1);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        conv_valid_i  = 1'b0;
        conv_last_i   = 1'b0;
        conv_result_i = '0;
        ofmap_size_i  = '0;
        pool_en_i     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(act_valid_o), 0);
        chk("rst_last", int'(act_last_o), 0);
        chk("rst_data", int'(act_data_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst_n = 1'b1;

        // 1: bypass S=2
        vals[0] = 5; vals[1] = -3; vals[2] = 0; vals[3] = 127;
        drive_map(2, 1'b0, 4, 3);

        // 2: pool S=4, 1..16
        for (int i = 0; i < 16; i++) vals[i] = i + 1;
        drive_map(4, 1'b1, 16, 15);

        // 3: pool S=4, all negative except beat 5
        for (int i = 0; i < 16; i++) vals[i] = -3 * (i + 1);
        vals[5] = 9;
        drive_map(4, 1'b1, 16, 15);

        // 4: pool S=5, 1..25, row 4 / col 4 dropped
        for (int i = 0; i < 25; i++) vals[i] = i + 1;
        drive_map(5, 1'b1, 25, 24);
        chk("err_clean", int'(err_o), 0);

        // 5: early conv_last on beat 4 of an S=3 bypass map
        for (int i = 0; i < 9; i++) vals[i] = 10 * i - 20;
        drive_map(3, 1'b0, 5, 4);
        chk("err_early_last", int'(err_o), 1);
        vals[0] = -7; vals[1] = 33; vals[2] = 100; vals[3] = -128;
        drive_map(2, 1'b0, 4, 3);
        chk("err_sticky", int'(err_o), 1);

        // 6: reset mid-map, then fresh S=2 pool map
        for (int i = 0; i < 16; i++) vals[i] = 50 - i;
        drive_map(4, 1'b1, 6, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("err_after_rst", int'(err_o), 0);
        chk("valid_after_rst", int'(act_valid_o), 0);
        vals[0] = 4; vals[1] = 3; vals[2] = 2; vals[3] = 1;
        drive_map(2, 1'b1, 4, 3);
        chk("err_t6", int'(err_o), 0);

        // 7: final beat without conv_last, then a well-formed map restarts from IDLE
        vals[0] = -1; vals[1] = 12; vals[2] = 77; vals[3] = 3;
        drive_map(2, 1'b1, 4, -1);
        chk("err_missing_last", int'(err_o), 1);
        vals[0] = 20; vals[1] = 21; vals[2] = -22; vals[3] = 19;
        drive_map(2, 1'b1, 4, 3);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
